// File: rtl/fp_mc_sequencer_if.sv
// fp_mc_sequencer_if: the signal bundle between the RV32IF pipeline and the FP div/sqrt sequencer.
//   Pipeline -> sequencer:
//     issue_valid_E, issue_op_E, issue_rd_E : multi-cycle op presented in E.
//     mc_op_D, Rs1D_f, Rs2D_f, use_rs1D_f, use_rs2D_f, RdD_f, fp_wr_D : D-stage operand info.
//     RegWriteW_f : the pipeline's own FP writeback this cycle.
//   Sequencer -> pipeline / unit:
//     unit_start, unit_op : start pulse and op select to the div/sqrt unit.
//     mc_wb_en, mc_wb_rd  : FP register-file write of the unit result.
//     mc_stall, busy      : hazard stall and occupancy.
// Modport "master" is the pipeline side; modport "slave" is the sequencer side.
interface fp_mc_sequencer_if;
  logic       issue_valid_E;
  logic       issue_op_E;
  logic [4:0] issue_rd_E;
  logic       mc_op_D;
  logic [4:0] Rs1D_f;
  logic [4:0] Rs2D_f;
  logic       use_rs1D_f;
  logic       use_rs2D_f;
  logic [4:0] RdD_f;
  logic       fp_wr_D;
  logic       RegWriteW_f;
  logic       unit_start;
  logic       unit_op;
  logic       mc_wb_en;
  logic [4:0] mc_wb_rd;
  logic       mc_stall;
  logic       busy;

  modport master (
    output issue_valid_E, issue_op_E, issue_rd_E,
    output mc_op_D, Rs1D_f, Rs2D_f, use_rs1D_f, use_rs2D_f, RdD_f, fp_wr_D,
    output RegWriteW_f,
    input  unit_start, unit_op, mc_wb_en, mc_wb_rd, mc_stall, busy
  );

  modport slave (
    input  issue_valid_E, issue_op_E, issue_rd_E,
    input  mc_op_D, Rs1D_f, Rs2D_f, use_rs1D_f, use_rs2D_f, RdD_f, fp_wr_D,
    input  RegWriteW_f,
    output unit_start, unit_op, mc_wb_en, mc_wb_rd, mc_stall, busy
  );
endinterface

// File: rtl/fp_mc_sequencer.sv
// fp_mc_sequencer: sequencer for the shared multi-cycle FP divide/square-root unit.
//   Accepts one fdiv.s/fsqrt.s from E, times the unit with a latency counter, arbitrates the
//   result onto the FP register-file write port behind the pipeline's own writeback, and stalls
//   D-stage instructions with a structural, RAW or WAW conflict on the pending destination.
// Ports:
//   clk   : clock, all state on the rising edge.
//   rst_n : asynchronous active-low reset; drops any in-flight result.
//   bus   : fp_mc_sequencer_if.slave bundle (issue, D-stage hazard inputs, W-stage write,
//           unit start/op, result writeback, stall and busy).
// Parameters:
//   DIV_LAT / SQRT_LAT : cycles from accept to earliest writeback, each >= 2.
//   CNT_W              : latency counter width, must hold max(DIV_LAT, SQRT_LAT).
module fp_mc_sequencer #(
  parameter int unsigned DIV_LAT  = 12,
  parameter int unsigned SQRT_LAT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input logic              clk,
  input logic              rst_n,
  fp_mc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWb   = 2'd2
  } state_e;

  // The accept cycle and the WB cycle each account for one cycle of latency, so the counter
  // only has to cover the remaining RUN cycles.
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LAT - 2);
  localparam logic [CNT_W-1:0] SqrtLoad = CNT_W'(SQRT_LAT - 2);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       r_rd;
  logic [4:0]       w_rd_nxt;
  logic             r_op;
  logic             w_op_nxt;

  logic             w_idle;
  logic             w_start;
  logic             w_wb_en;
  logic [4:0]       w_trk_rd;
  logic             w_trk_v;
  logic             w_hit_rs1;
  logic             w_hit_rs2;
  logic             w_hit_rd;

  assign w_idle  = (r_state == StIdle);
  // issue_valid_E is only honoured in IDLE; elsewhere the structural stall keeps it away.
  assign w_start = w_idle & bus.issue_valid_E;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd    <= w_rd_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state and writeback arbitration.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = r_rd;
    w_op_nxt    = r_op;
    w_wb_en     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.issue_valid_E) begin
          w_rd_nxt    = bus.issue_rd_E;
          w_op_nxt    = bus.issue_op_E;
          w_cnt_nxt   = bus.issue_op_E ? SqrtLoad : DivLoad;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (r_cnt == '0) begin
          w_state_nxt = StWb;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      StWb: begin
        // The pipeline's own FP write wins the port; the unit holds its result until acked.
        w_wb_en = ~bus.RegWriteW_f;
        if (w_wb_en) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Hazard tracking: in the accept cycle the destination comes straight from E so a dependent
  // instruction in D is caught before rd_q is loaded.
  assign w_trk_rd  = w_idle ? bus.issue_rd_E : r_rd;
  assign w_trk_v   = ~w_idle | bus.issue_valid_E;
  assign w_hit_rs1 = bus.use_rs1D_f & (bus.Rs1D_f == w_trk_rd);
  assign w_hit_rs2 = bus.use_rs2D_f & (bus.Rs2D_f == w_trk_rd);
  assign w_hit_rd  = bus.fp_wr_D & (bus.RdD_f == w_trk_rd);

  assign bus.mc_stall   = w_trk_v & (bus.mc_op_D | w_hit_rs1 | w_hit_rs2 | w_hit_rd);
  assign bus.unit_start = w_start;
  // Outside the start pulse the latched op is presented, which is zero after reset.
  assign bus.unit_op    = w_start ? bus.issue_op_E : r_op;
  assign bus.mc_wb_en   = w_wb_en;
  assign bus.mc_wb_rd   = (r_state == StWb) ? r_rd : 5'd0;
  assign bus.busy       = ~w_idle;

endmodule
